// File: rtl/rv_lite_pkg.sv
// Shared decode definitions for the RISC-V-lite pipeline: opcodes, ALU codes
// and the control bundle carried in the ID/EX register.
package rv_lite_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [3:0] ALU_ADD = 4'b0001;
    localparam logic [3:0] ALU_SUB = 4'b0010;
    localparam logic [3:0] ALU_AND = 4'b0011;
    localparam logic [3:0] ALU_OR  = 4'b0100;
    localparam logic [3:0] ALU_XOR = 4'b0101;
    localparam logic [3:0] ALU_SLT = 4'b0110;
    localparam logic [3:0] ALU_SRA = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;
    localparam logic [3:0] ALU_LEQ = 4'b1011;
    localparam logic [3:0] ALU_EQ  = 4'b1100;

    typedef struct packed {
        logic       regWrite;
        logic       memRead;
        logic       memWrite;
        logic       memToReg;
        logic       branch;
        logic       jump;
        logic       muxSel;
        logic [3:0] aluControl;
    } ctrl_t;

    // An all-zero control word is a no-op in every downstream stage.
    localparam ctrl_t BUBBLE = '0;

endpackage

// File: rtl/decode_regfile.sv
// Integer register file: 2 combinational read ports with write-through bypass,
// 1 synchronous write port, x0 hardwired to zero, synchronous active-low clear.
module decode_regfile #(
    parameter int N    = 64,
    parameter int NREG = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [4:0]   raddr1,
    input  logic [4:0]   raddr2,
    output logic [N-1:0] rdata1,
    output logic [N-1:0] rdata2,
    input  logic         wbEn,
    input  logic [4:0]   wbAddr,
    input  logic [N-1:0] wbData
);

    logic [NREG-1:0][N-1:0] regs;

    always_ff @(posedge clk) begin
        if (!rst)
            regs <= '0;
        else if (wbEn && wbAddr != 5'd0)
            regs[wbAddr] <= wbData;
    end

    // Bypass lets a writeback in this cycle reach the instruction being decoded.
    function automatic logic [N-1:0] rdport(input logic [4:0] a);
        if (a == 5'd0)
            return '0;
        if (wbEn && wbAddr == a)
            return wbData;
        return regs[a];
    endfunction

    always_comb begin
        rdata1 = rdport(raddr1);
        rdata2 = rdport(raddr2);
    end

endmodule

// File: rtl/decode_stage.sv
// ID stage: decodes one instruction per cycle, reads the register file and
// loads the ID/EX register feeding execute; also detects load-use hazards.
module decode_stage
    import rv_lite_pkg::*;
#(
    parameter int N    = 64,
    parameter int NREG = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         regEn,
    input  logic         flush,
    input  logic [31:0]  instr,
    input  logic [N-1:0] NPCin,
    input  logic         wbEn,
    input  logic [4:0]   wbAddr,
    input  logic [N-1:0] wbData,
    output logic [N-1:0] NPCout,
    output logic [N-1:0] A,
    output logic [N-1:0] B,
    output logic [N-1:0] Imm,
    output logic         muxSel,
    output logic [3:0]   aluControl,
    output logic [4:0]   rdOut,
    output logic         regWrite,
    output logic         memRead,
    output logic         memWrite,
    output logic         memToReg,
    output logic         branch,
    output logic         jump,
    output logic         stall,
    output logic         illegal
);

    logic [6:0] opcode, f7;
    logic [4:0] rs1, rs2, rd;
    logic [2:0] f3;
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign f3     = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign f7     = instr[31:25];

    logic [N-1:0] rs1v, rs2v;

    decode_regfile #(.N(N), .NREG(NREG)) u_rf (
        .clk    (clk),
        .rst    (rst),
        .raddr1 (rs1),
        .raddr2 (rs2),
        .rdata1 (rs1v),
        .rdata2 (rs2v),
        .wbEn   (wbEn),
        .wbAddr (wbAddr),
        .wbData (wbData)
    );

    logic [N-1:0] immI, immS, immB, immU, immJ, immSh;
    assign immI  = {{(N-12){instr[31]}}, instr[31:20]};
    assign immS  = {{(N-12){instr[31]}}, instr[31:25], instr[11:7]};
    assign immB  = {{(N-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    assign immU  = {{(N-32){instr[31]}}, instr[31:12], 12'b0};
    assign immJ  = {{(N-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    assign immSh = {{(N-6){1'b0}}, instr[25:20]};

    ctrl_t        dc;
    logic [N-1:0] da, db, dimm;
    logic [4:0]   drd;
    logic         use1, use2, dill;

    always_comb begin
        dc   = BUBBLE;
        da   = '0;
        db   = '0;
        dimm = '0;
        drd  = '0;
        use1 = 1'b0;
        use2 = 1'b0;
        dill = 1'b0;
        case (opcode)
            OP_R: begin
                use1 = 1'b1; use2 = 1'b1;
                da = rs1v; db = rs2v;
                dc.regWrite = 1'b1; drd = rd;
                case ({f7, f3})
                    {7'h00, 3'b000}: dc.aluControl = ALU_ADD;
                    {7'h20, 3'b000}: dc.aluControl = ALU_SUB;
                    {7'h00, 3'b001}: dc.aluControl = ALU_SLL;
                    {7'h00, 3'b010}: dc.aluControl = ALU_SLT;
                    {7'h00, 3'b100}: dc.aluControl = ALU_XOR;
                    {7'h00, 3'b101}: dc.aluControl = ALU_SRL;
                    {7'h20, 3'b101}: dc.aluControl = ALU_SRA;
                    {7'h00, 3'b110}: dc.aluControl = ALU_OR;
                    {7'h00, 3'b111}: dc.aluControl = ALU_AND;
                    default:         dill = 1'b1;
                endcase
            end
            OP_IMM: begin
                use1 = 1'b1;
                da = rs1v; dimm = immI;
                dc.muxSel = 1'b1; dc.regWrite = 1'b1; drd = rd;
                case (f3)
                    3'b000: dc.aluControl = ALU_ADD;
                    3'b010: dc.aluControl = ALU_SLT;
                    3'b100: dc.aluControl = ALU_XOR;
                    3'b110: dc.aluControl = ALU_OR;
                    3'b111: dc.aluControl = ALU_AND;
                    3'b001: begin
                        dimm = immSh;
                        if (instr[31:26] == 6'b000000) dc.aluControl = ALU_SLL;
                        else dill = 1'b1;
                    end
                    3'b101: begin
                        dimm = immSh;
                        if (instr[31:26] == 6'b000000)      dc.aluControl = ALU_SRL;
                        else if (instr[31:26] == 6'b010000) dc.aluControl = ALU_SRA;
                        else dill = 1'b1;
                    end
                    default: dill = 1'b1;
                endcase
            end
            OP_LOAD: begin
                use1 = 1'b1;
                da = rs1v; dimm = immI; drd = rd;
                dc.aluControl = ALU_ADD; dc.muxSel = 1'b1;
                dc.memRead = 1'b1; dc.memToReg = 1'b1; dc.regWrite = 1'b1;
                if (f3 != 3'b010 && f3 != 3'b011) dill = 1'b1;
            end
            OP_STORE: begin
                use1 = 1'b1; use2 = 1'b1;
                da = rs1v; db = rs2v; dimm = immS;
                dc.aluControl = ALU_ADD; dc.muxSel = 1'b1; dc.memWrite = 1'b1;
                if (f3 != 3'b010 && f3 != 3'b011) dill = 1'b1;
            end
            OP_BRANCH: begin
                use1 = 1'b1; use2 = 1'b1;
                dimm = immB; dc.branch = 1'b1;
                // BGE is computed as rs2 <= rs1, so the operands swap.
                case (f3)
                    3'b000:  begin da = rs1v; db = rs2v; dc.aluControl = ALU_EQ;  end
                    3'b101:  begin da = rs2v; db = rs1v; dc.aluControl = ALU_LEQ; end
                    default: dill = 1'b1;
                endcase
            end
            OP_LUI: begin
                dimm = immU; drd = rd;
                dc.muxSel = 1'b1; dc.aluControl = ALU_ADD; dc.regWrite = 1'b1;
            end
            OP_AUIPC: begin
                da = NPCin; dimm = immU; drd = rd;
                dc.muxSel = 1'b1; dc.aluControl = ALU_ADD; dc.regWrite = 1'b1;
            end
            OP_JAL: begin
                da = NPCin; db = N'(4); dimm = immJ; drd = rd;
                dc.aluControl = ALU_ADD; dc.jump = 1'b1; dc.regWrite = 1'b1;
            end
            default: dill = 1'b1;
        endcase
    end

    ctrl_t ctrl_q;

    assign stall = ctrl_q.memRead && rdOut != 5'd0 &&
                   ((rdOut == rs1 && use1) || (rdOut == rs2 && use2));

    always_ff @(posedge clk) begin
        if (!rst) begin
            ctrl_q  <= BUBBLE;
            NPCout  <= '0;
            A       <= '0;
            B       <= '0;
            Imm     <= '0;
            rdOut   <= '0;
            illegal <= 1'b0;
        end else if (regEn) begin
            if (flush || stall || dill) begin
                ctrl_q  <= BUBBLE;
                NPCout  <= '0;
                A       <= '0;
                B       <= '0;
                Imm     <= '0;
                rdOut   <= '0;
                // A squashed or re-presented instruction is not reported yet.
                illegal <= dill && !flush && !stall;
            end else begin
                ctrl_q  <= dc;
                NPCout  <= NPCin;
                A       <= da;
                B       <= db;
                Imm     <= dimm;
                rdOut   <= drd;
                illegal <= 1'b0;
            end
        end
    end

    assign regWrite   = ctrl_q.regWrite;
    assign memRead    = ctrl_q.memRead;
    assign memWrite   = ctrl_q.memWrite;
    assign memToReg   = ctrl_q.memToReg;
    assign branch     = ctrl_q.branch;
    assign jump       = ctrl_q.jump;
    assign muxSel     = ctrl_q.muxSel;
    assign aluControl = ctrl_q.aluControl;

endmodule
